// File: rtl/pulse_gen_mux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pulse_gen_pkg
// Description : Shared types, selector constants and width helpers for the
//               multi-channel pulse generator.
// Revision    : 1.0 - initial release
// ============================================================================
package pulse_gen_pkg;

  // Channel output style
  typedef enum logic {
    MODE_SQUARE = 1'b0,
    MODE_TICK   = 1'b1
  } mode_e;

  // Selector value that forces the output low
  localparam int SEL_ZERO = 0;

  // Selector value that forces the output high (one past the last channel)
  function automatic int sel_one(input int n_ch);
    return n_ch + 1;
  endfunction

  // Selector width: codes 0..n_ch+1 must all be representable
  function automatic int sel_width(input int n_ch);
    return $clog2(n_ch + 2);
  endfunction

  // Channel-index width, never narrower than one bit
  function automatic int ch_width(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pulse_gen_mux_if.sv
`default_nettype none
// ============================================================================
// Module      : pulse_gen_mux_if
// Description : Valid/ready divisor-reload port of the pulse generator.
// Revision    : 1.0 - initial release
// ============================================================================
interface pulse_gen_mux_if #(
  parameter int N_CH  = 4,
  parameter int DIV_W = 26
);
  import pulse_gen_pkg::*;

  localparam int CH_W = ch_width(N_CH);

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [DIV_W-1:0] cfg_div;
  mode_e            cfg_mode;

  modport master (
    output cfg_valid, cfg_ch, cfg_div, cfg_mode,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_div, cfg_mode,
    output cfg_ready
  );

endinterface
`default_nettype wire

// File: rtl/pulse_gen_mux_channel.sv
`default_nettype none
// ============================================================================
// Module      : pulse_gen_channel
// Description : One divider channel: terminal counter, square/tick output
//               and a divisor/mode register reloaded on an apply command.
// Revision    : 1.0 - initial release
// ============================================================================
module pulse_gen_channel
  import pulse_gen_pkg::*;
#(
  parameter int               DIV_W   = 26,
  parameter logic [DIV_W-1:0] DIV_RST = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             apply_i,
  input  logic [DIV_W-1:0] apply_div_i,
  input  mode_e            apply_mode_i,
  output logic             terminal_o,
  output logic             ch_out_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  mode_e            mode_q, mode_d;
  logic             out_q, out_d;
  logic             w_term;

  assign w_term     = en_i && (cnt_q == div_q);
  assign terminal_o = w_term;
  assign ch_out_o   = out_q;

  // Next state: a reload restarts the period cleanly, otherwise count and shape
  always_comb begin
    cnt_d  = cnt_q;
    out_d  = out_q;
    div_d  = div_q;
    mode_d = mode_q;
    if (apply_i) begin
      div_d  = apply_div_i;
      mode_d = apply_mode_i;
      cnt_d  = '0;
      out_d  = 1'b0;
    end else if (!en_i) begin
      cnt_d = '0;
      out_d = 1'b0;
    end else if (w_term) begin
      cnt_d = '0;
      out_d = (mode_q == MODE_TICK) ? 1'b1 : ~out_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
      if (mode_q == MODE_TICK) begin
        out_d = 1'b0;
      end
    end
  end

  // Channel state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      out_q  <= 1'b0;
      div_q  <= DIV_RST;
      mode_q <= MODE_SQUARE;
    end else begin
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      div_q  <= div_d;
      mode_q <= mode_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pulse_gen_mux.sv
`default_nettype none
// ============================================================================
// Module      : pulse_gen_mux
// Description : N_CH programmable pulse generators with a staged config port
//               and a glitch-free registered output selector.
// Revision    : 1.0 - initial release
// ============================================================================
module pulse_gen_mux
  import pulse_gen_pkg::*;
#(
  parameter int          CLK_FREQ = 50_000_000,
  parameter int          N_CH     = 4,
  parameter int          DIV_W    = 26,
  parameter int unsigned DIV_RST  = CLK_FREQ / 2 - 1,
  parameter int          SEL_W    = sel_width(N_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  pulse_gen_mux_if.slave    cfg,
  input  logic [N_CH-1:0]   ch_en_i,
  input  logic [SEL_W-1:0]  sel_i,
  output logic [N_CH-1:0]   ch_out_o,
  output logic              out_o,
  output logic              sel_busy_o
);

  localparam int               CH_W      = ch_width(N_CH);
  localparam logic [DIV_W-1:0] c_div_rst = DIV_W'(DIV_RST);
  localparam logic [SEL_W-1:0] c_sel_0   = SEL_W'(SEL_ZERO);
  localparam logic [SEL_W-1:0] c_sel_1   = SEL_W'(sel_one(N_CH));

  // Staged configuration write
  logic             pend_q;
  logic [CH_W-1:0]  st_ch_q;
  logic [DIV_W-1:0] st_div_q;
  mode_e            st_mode_q;

  logic             w_accept;
  logic             w_bad_ch;
  logic [N_CH-1:0]  w_hit;
  logic [N_CH-1:0]  w_apply;
  logic [N_CH-1:0]  w_term;
  logic [N_CH-1:0]  w_ch_out;

  // Selector state
  logic [SEL_W-1:0] act_sel_q;
  logic             out_q;
  logic             busy_q;
  logic             w_src;
  logic             w_can_switch;

  assign cfg.cfg_ready = ~pend_q;
  assign w_accept      = cfg.cfg_valid && ~pend_q;
  assign w_bad_ch      = ~|w_hit;

  // A staged write lands on the target's terminal event, or at once if it is idle
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign w_hit[i]   = (st_ch_q == CH_W'(i));
    assign w_apply[i] = pend_q && w_hit[i] && (!ch_en_i[i] || w_term[i]);

    pulse_gen_channel #(
      .DIV_W   (DIV_W),
      .DIV_RST (c_div_rst)
    ) u_ch (
      .clk          (clk),
      .rst_n        (rst_n),
      .en_i         (ch_en_i[i]),
      .apply_i      (w_apply[i]),
      .apply_div_i  (st_div_q),
      .apply_mode_i (st_mode_q),
      .terminal_o   (w_term[i]),
      .ch_out_o     (w_ch_out[i])
    );
  end

  // Config stage: capture on handshake, release once applied or found out of range
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q    <= 1'b0;
      st_ch_q   <= '0;
      st_div_q  <= '0;
      st_mode_q <= MODE_SQUARE;
    end else if (w_accept) begin
      pend_q    <= 1'b1;
      st_ch_q   <= cfg.cfg_ch;
      st_div_q  <= cfg.cfg_div;
      st_mode_q <= cfg.cfg_mode;
    end else if (pend_q && (w_bad_ch || (|w_apply))) begin
      pend_q <= 1'b0;
    end
  end

  // Source currently routed to the output; unused codes read as constant 0
  always_comb begin
    w_src = 1'b0;
    if (act_sel_q == c_sel_1) begin
      w_src = 1'b1;
    end
    for (int i = 0; i < N_CH; i++) begin
      if (act_sel_q == SEL_W'(i + 1)) begin
        w_src = w_ch_out[i];
      end
    end
  end

  // Switching only while low (or away from const 1) keeps high pulses whole
  assign w_can_switch = !out_q || (act_sel_q == c_sel_1);

  // Selector: registered output plus deferred source switch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_sel_q <= c_sel_0;
      out_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      out_q <= w_src;
      if (sel_i != act_sel_q) begin
        if (w_can_switch) begin
          act_sel_q <= sel_i;
          busy_q    <= 1'b0;
        end else begin
          busy_q <= 1'b1;
        end
      end else begin
        busy_q <= 1'b0;
      end
    end
  end

  assign ch_out_o   = w_ch_out;
  assign out_o      = out_q;
  assign sel_busy_o = busy_q;

endmodule
`default_nettype wire
